alu_seq: RTL and testbench
==========================

# alu_seq

Sequenced ALU stage of the tiny RISC CPU, sitting directly upstream of the accumulator (AC). It takes an operation request from the controller along with the current AC value and a memory operand. It computes an 8-bit result, then presents it on `ac_data` with a one-cycle `ac_load` strobe that drives the AC's `data_in`/`load` pins. Simple ops take one cycle; the optional iterative multiply takes several cycles and holds off new requests via `busy`.

## Interface
- `WIDTH`, 8, datapath width; AC width must match.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request strobe; sampled on rising edge.
- `opcode`  in  3  operation select, captured with `start`.
- `acc_in`  in  WIDTH  current AC `data_out`, captured with `start`.
- `opnd`  in  WIDTH  memory operand, captured with `start`.
- `busy`  out  1  high while a multi-cycle op is in progress.
- `done`  out  1  one-cycle completion pulse, coincident with `ac_load`.
- `ac_data`  out  WIDTH  registered result, wired to AC `data_in`.
- `ac_load`  out  1  one-cycle load strobe, wired to AC `load`.
- `zero`  out  1  registered: result == 0.
- `carry`  out  1  registered carry/borrow/overflow of the result.
- `illegal`  out  1  registered: last accepted opcode was not supported.

## Operation
- Opcodes:
  - 000 PASS: result = `opnd`.
  - 001 ADD: result = `acc_in` + `opnd`; `carry` = bit WIDTH of the sum.
  - 010 SUB: result = `acc_in` − `opnd`; `carry` = borrow (1 when `opnd` > `acc_in`).
  - 011 AND and 100 XOR: bitwise on `acc_in`, `opnd`; `carry` = 0.
  - 101 SHL: result = `acc_in` << 1; `carry` = old MSB.
  - 110 SHR: result = `acc_in` >> 1, logical; `carry` = old LSB.
  - 111 MUL: result = low WIDTH bits of `acc_in` × `opnd`; `carry` = 1 if the high WIDTH bits are nonzero.
- All arithmetic is unsigned and modulo 2^WIDTH.
- FSM states:
  - IDLE: waits for `start`.
  - MUL: iterative multiply, one shift-add step per cycle, internal counter WIDTH−1 down to 0.
  - DONE: asserts `ac_load`/`done` for one cycle.
- Transitions:
  - IDLE + `start`, non-MUL op → DONE, result registered at the same edge.
  - IDLE + `start`, MUL → MUL.
  - MUL, counter reaches 0 → DONE.
  - DONE → IDLE, or DONE → DONE/MUL if `start` is sampled in DONE (back-to-back accepted).
- `start` is ignored while in MUL (`busy`=1). It is not queued.
- `ac_data`, `zero`, `carry` and `illegal` hold their last values until the next completion.
- Reset mid-operation aborts the op: no `ac_load` is issued for it.
- Reset values: state IDLE; `busy`, `done`, `ac_load`, `carry`, `illegal` all 0; `ac_data` 0; `zero` 1.

## Timing
- Non-MUL op: `start` sampled at edge E0 → `ac_load`/`done`/`ac_data` valid from E0 to E1 → AC captures at E1. Latency is 1 cycle.
- MUL: `start` at E0 → `busy` high E0..E(WIDTH) → `ac_load` high E(WIDTH)..E(WIDTH+1). That is 9 cycles to AC capture at WIDTH=8.
- `busy` drops at the same edge `ac_load` rises.
- Throughput: one non-MUL op per cycle when `start` is held high each cycle.
- `acc_in`/`opnd` changing after the capture edge has no effect on an in-flight op.
- `start` in the same cycle as active `rst_n`=0: reset wins, and the request is dropped.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL opcode is implemented as described; `illegal` is never set.
- `ALU_SEQ_MUL_EN` undefined:
  - MUL state and multiplier logic are removed.
  - Opcode 111 completes in 1 cycle with result = `acc_in` unchanged, `carry` = 0, `illegal` = 1.
  - `busy` is tied 0.

## Structure
- Shared package `alu_seq_pkg`: opcode constants (`OP_PASS` … `OP_MUL`), FSM state encoding, `WIDTH` default. The controller imports the same opcode constants.
- One sub-module, `alu_mul_iter`: shift-add multiplier with `load`/`step` inputs and `prod_lo`/`prod_hi`/`last` outputs. It is instantiated only under `ALU_SEQ_MUL_EN`.
- Single-cycle ops are a combinational case in the top level feeding the result registers.

## Test plan
- Reset, then hold `rst_n`=0 for 2 cycles → `ac_data`=0, `zero`=1, `ac_load`=0, `busy`=0.
- PASS, `opnd`=34 → `ac_load` pulse one cycle later, `ac_data`=34, `zero`=0. AC model then holds 34.
- ADD, `acc_in`=200, `opnd`=100 → `ac_data`=44, `carry`=1. SUB, `acc_in`=16, `opnd`=34 → `ac_data`=238, `carry`=1.
- MUL (with `ALU_SEQ_MUL_EN`), `acc_in`=34, `opnd`=16:
  - `busy` high 8 cycles, then `ac_data`=32, `carry`=1, single `done` pulse.
  - A `start` pulsed mid-MUL is ignored.
- Back-to-back: AND 0xF0/0x3C then XOR 0xFF/0x0F on consecutive cycles → `ac_data` 0x30 then 0xF0, two consecutive `ac_load` pulses.
- Reset asserted on the 4th MUL cycle → no `ac_load`, state IDLE, outputs at reset values. Without `ALU_SEQ_MUL_EN`, opcode 111 with `acc_in`=5 → `ac_data`=5, `illegal`=1 after 1 cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU stage: opcode constants, FSM state
// encoding and default datapath width. Also used by the CPU controller.
package alu_seq_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_MUL  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, MSB-first, one partial product per step.
// prod_lo/prod_hi present the product as it stands after the current step.
module alu_mul_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [CW-1:0]      cnt_r;

    // Next partial product: shift accumulator, add multiplicand if bit cnt_r of b is set
    always_comb begin
        acc_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
        if (b_r[cnt_r]) begin
            acc_next_s = acc_next_s + {{WIDTH{1'b0}}, a_r};
        end else begin
            acc_next_s = acc_next_s;
        end
    end

    // Operand capture on load, one accumulation step per cycle on step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            acc_r <= {(2*WIDTH){1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= {(2*WIDTH){1'b0}};
            cnt_r <= CW'(WIDTH - 1);
        end else if (step) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r - CW'(1);
        end
    end

    assign prod_lo = acc_next_s[WIDTH-1:0];
    assign prod_hi = acc_next_s[2*WIDTH-1:WIDTH];
    assign last    = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU stage feeding the accumulator's data_in/load pins.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for opcode 111.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] opnd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_data,
    output logic             ac_load,
    output logic             zero,
    output logic             carry,
    output logic             illegal
);

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_carry_s;
    logic             alu_illegal_s;
    logic [WIDTH-1:0] res_s;
    logic             res_carry_s;
    logic             res_illegal_s;
    logic             load_res_s;
    logic [WIDTH-1:0] ac_data_r;
    logic             ac_load_r;
    logic             zero_r;
    logic             carry_r;
    logic             illegal_r;

`ifdef ALU_SEQ_MUL_EN
    logic             mul_load_s;
    logic             mul_step_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic             mul_last_s;
    logic             busy_r;

    assign mul_step_s = (state_r == ST_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load_s),
        .step    (mul_step_s),
        .a       (acc_in),
        .b       (opnd),
        .prod_lo (mul_lo_s),
        .prod_hi (mul_hi_s),
        .last    (mul_last_s)
    );

    // busy mirrors the registered "next state is MUL" decision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_MUL);
        end
    end

    assign busy = busy_r;
`else
    assign busy = 1'b0;
`endif

    // Single-cycle operations on the live request operands
    always_comb begin
        sum_s         = {1'b0, acc_in} + {1'b0, opnd};
        diff_s        = {1'b0, acc_in} - {1'b0, opnd};
        alu_res_s     = opnd;
        alu_carry_s   = 1'b0;
        alu_illegal_s = 1'b0;
        case (opcode)
            OP_PASS: alu_res_s = opnd;
            OP_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                alu_res_s   = diff_s[WIDTH-1:0];
                alu_carry_s = diff_s[WIDTH];
            end
            OP_AND: alu_res_s = acc_in & opnd;
            OP_XOR: alu_res_s = acc_in ^ opnd;
            OP_SHL: begin
                alu_res_s   = {acc_in[WIDTH-2:0], 1'b0};
                alu_carry_s = acc_in[WIDTH-1];
            end
            OP_SHR: begin
                alu_res_s   = {1'b0, acc_in[WIDTH-1:1]};
                alu_carry_s = acc_in[0];
            end
            OP_MUL: begin
                // Without the multiplier, 111 passes AC through and flags illegal
                alu_res_s = acc_in;
`ifdef ALU_SEQ_MUL_EN
                alu_illegal_s = 1'b0;
`else
                alu_illegal_s = 1'b1;
`endif
            end
            default: alu_res_s = opnd;
        endcase
    end

    // Next-state and result-select logic; DONE accepts a new request like IDLE
    always_comb begin
        state_next_s  = state_r;
        load_res_s    = 1'b0;
        res_s         = alu_res_s;
        res_carry_s   = alu_carry_s;
        res_illegal_s = alu_illegal_s;
`ifdef ALU_SEQ_MUL_EN
        mul_load_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
`ifdef ALU_SEQ_MUL_EN
                    if (opcode == OP_MUL) begin
                        state_next_s = ST_MUL;
                        mul_load_s   = 1'b1;
                    end else begin
                        state_next_s = ST_DONE;
                        load_res_s   = 1'b1;
                    end
`else
                    state_next_s = ST_DONE;
                    load_res_s   = 1'b1;
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                res_s         = mul_lo_s;
                res_carry_s   = |mul_hi_s;
                res_illegal_s = 1'b0;
                if (mul_last_s) begin
                    state_next_s = ST_DONE;
                    load_res_s   = 1'b1;
                end else begin
                    state_next_s = ST_MUL;
                end
`else
                state_next_s = ST_IDLE;
`endif
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State and result registers; flags hold until the next completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ac_load_r <= 1'b0;
            ac_data_r <= {WIDTH{1'b0}};
            zero_r    <= 1'b1;
            carry_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ac_load_r <= load_res_s;
            if (load_res_s) begin
                ac_data_r <= res_s;
                zero_r    <= (res_s == {WIDTH{1'b0}});
                carry_r   <= res_carry_s;
                illegal_r <= res_illegal_s;
            end
        end
    end

    assign ac_data = ac_data_r;
    assign ac_load = ac_load_r;
    assign done    = ac_load_r;
    assign zero    = zero_r;
    assign carry   = carry_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and randomized requests checked
// against an arithmetic reference model; honours ALU_SEQ_MUL_EN.
module tb_alu_seq;

    localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] acc_in;
    logic [W-1:0] opnd;
    logic         busy, done, ac_load, zero, carry, illegal;
    logic [W-1:0] ac_data;
    logic [13:0]  obs;
    logic [W-1:0] ac_model;
    int           checks = 0;
    int           errors = 0;

    alu_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .opcode  (opcode),
        .acc_in  (acc_in),
        .opnd    (opnd),
        .busy    (busy),
        .done    (done),
        .ac_data (ac_data),
        .ac_load (ac_load),
        .zero    (zero),
        .carry   (carry),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // {ac_load, done, busy, zero, carry, illegal, ac_data}
    assign obs = {ac_load, done, busy, zero, carry, illegal, ac_data};

    // Downstream accumulator register
    always @(posedge clk) begin
        if (!rst_n) ac_model <= '0;
        else if (ac_load) ac_model <= ac_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input int op, input int a, input int b,
                                  output int res, output bit c, output bit ill);
        int full;
        ill = 1'b0;
        c   = 1'b0;
        case (op)
            0: res = b;
            1: begin full = a + b; res = full % 256; c = (full > 255); end
            2: begin res = (a - b + 256) % 256; c = (b > a); end
            3: res = a & b;
            4: res = a ^ b;
            5: begin full = a * 2; res = full % 256; c = (full > 255); end
            6: begin res = a / 2; c = ((a % 2) == 1); end
            default: begin
                if (MUL_EN) begin
                    full = a * b; res = full % 256; c = ((full / 256) != 0);
                end else begin
                    res = a; ill = 1'b1;
                end
            end
        endcase
    endfunction

    // One isolated request: expected latency, completion values, then hold
    task automatic run_op(input int op, input int a, input int b, input string tag);
        int res; bit c, ill; bit is_mul;
        logic [13:0] e;
        model(op, a, b, res, c, ill);
        is_mul = MUL_EN && (op == 7);
        opcode = 3'(op); acc_in = 8'(a); opnd = 8'(b); start = 1'b1;
        cyc();
        start = 1'b0; acc_in = 8'($urandom); opnd = 8'($urandom);
        if (is_mul) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if ({busy, ac_load, done} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s busy-phase cycle %0d busy/load/done=%b expected 100", tag, k, {busy, ac_load, done});
                end
                cyc();
            end
        end
        e = {1'b1, 1'b1, 1'b0, (res == 0), c, ill, 8'(res)};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s op=%0d a=%0d b=%0d complete got %h expected %h", tag, op, a, b, obs, e);
        end
        cyc();
        e[13:11] = 3'b000;
        checks++;
        if (obs !== e || ac_model !== 8'(res)) begin
            errors++;
            $display("FAIL %s hold got %h ac=%0d expected %h ac=%0d", tag, obs, ac_model, e, res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; opcode = '0; acc_in = '0; opnd = '0;
        cyc(); cyc();
        checks++;
        if (obs !== 14'b00_0_1_0_0_00000000) begin
            errors++;
            $display("FAIL reset got %h expected %h", obs, 14'b00_0_1_0_0_00000000);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_directed();
        run_op(0, 34, 0, "pass34");
        run_op(1, 200, 100, "add");
        run_op(2, 16, 34, "sub");
        run_op(2, 34, 34, "sub_zero");
        run_op(5, 8'h81, 0, "shl");
        run_op(6, 8'h03, 0, "shr");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), "random");
        end
    endtask

    // Consecutive non-MUL requests with start held high
    task automatic test_back_to_back();
        int res; bit c, ill; int op, a, b;
        logic [13:0] e;
        opcode = 3'd3; acc_in = 8'hF0; opnd = 8'h3C; start = 1'b1;
        cyc();
        opcode = 3'd4; acc_in = 8'hFF; opnd = 8'h0F;
        checks++;
        if (ac_load !== 1'b1 || ac_data !== 8'h30) begin
            errors++;
            $display("FAIL b2b_and load=%b data=%h expected 1 30", ac_load, ac_data);
        end
        cyc();
        checks++;
        if (ac_load !== 1'b1 || ac_data !== 8'hF0) begin
            errors++;
            $display("FAIL b2b_xor load=%b data=%h expected 1 f0", ac_load, ac_data);
        end
        for (int i = 0; i < 12; i++) begin
            op = int'($urandom_range(0, MUL_EN ? 6 : 7));
            a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
            model(op, a, b, res, c, ill);
            opcode = 3'(op); acc_in = 8'(a); opnd = 8'(b);
            cyc();
            e = {1'b1, 1'b1, 1'b0, (res == 0), c, ill, 8'(res)};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b_random op=%0d a=%0d b=%0d got %h expected %h", op, a, b, obs, e);
            end
        end
        start = 1'b0;
        cyc();
        checks++;
        if (ac_load !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end load=%b expected 0", ac_load);
        end
    endtask

    task automatic test_reset_vs_start();
        rst_n = 1'b0; start = 1'b1; opcode = 3'd0; opnd = 8'd77;
        cyc();
        rst_n = 1'b1; start = 1'b0;
        checks++;
        if (obs !== 14'b00_0_1_0_0_00000000) begin
            errors++;
            $display("FAIL reset_vs_start got %h expected %h", obs, 14'b00_0_1_0_0_00000000);
        end
        cyc();
        checks++;
        if (ac_load !== 1'b0 || ac_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_vs_start_after load=%b data=%0d expected 0 0", ac_load, ac_data);
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        int loads = 0;
        opcode = 3'd7; acc_in = 8'd34; opnd = 8'd16; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (busy !== 1'b1 || ac_load !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy cycle %0d busy=%b load=%b expected 1 0", k, busy, ac_load);
            end
            if (k == 3) begin
                start = 1'b1; opcode = 3'd0; opnd = 8'd99;
            end else begin
                start = 1'b0;
            end
            cyc();
        end
        start = 1'b0;
        checks++;
        if (obs !== {3'b110, 1'b0, 1'b1, 1'b0, 8'd32}) begin
            errors++;
            $display("FAIL mul_result got %h expected %h", obs, {3'b110, 1'b0, 1'b1, 1'b0, 8'd32});
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (ac_load) loads++;
        end
        checks++;
        if (loads != 0 || ac_data !== 8'd32 || ac_model !== 8'd32) begin
            errors++;
            $display("FAIL mul_no_extra loads=%0d data=%0d ac=%0d expected 0 32 32", loads, ac_data, ac_model);
        end
    endtask

    task automatic test_reset_mid_mul();
        int loads = 0;
        run_op(0, 55, 55, "pre_abort");
        opcode = 3'd7; acc_in = 8'd200; opnd = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if (obs !== 14'b00_0_1_0_0_00000000) begin
            errors++;
            $display("FAIL abort_mul got %h expected %h", obs, 14'b00_0_1_0_0_00000000);
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (ac_load || busy) loads++;
        end
        checks++;
        if (loads != 0) begin
            errors++;
            $display("FAIL abort_mul_after stray load/busy cycles=%0d expected 0", loads);
        end
    endtask
`else
    task automatic test_illegal();
        run_op(7, 5, 9, "illegal111");
        run_op(0, 0, 0, "illegal_clear");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_reset_mid_mul();
`else
        test_illegal();
`endif
        test_random();
        test_reset_vs_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
